pcm_stream_ctrl: RTL and testbench

- Sample-rate scheduler that feeds the 8-bit PWM DAC.
- The CPU pushes PCM bytes into an internal FIFO. A programmable rate divider pops one byte per sample period and presents it to the DAC as a one-cycle write strobe plus data.
- Handles underrun by emitting midscale (8'h80).
- Exposes FIFO level, a half-empty interrupt and a sticky underrun flag for the SoC register block.

---
 rtl/pcm_stream_ctrl.sv | 104 ++++++++++
 tb/tb_pcm_stream_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/pcm_stream_ctrl.sv
// pcm_stream_ctrl: sample-rate scheduler that drains a PCM byte FIFO into the PWM DAC,
// parking the DAC at midscale on underrun or stop.
module pcm_stream_ctrl #(
    parameter int          FIFO_DEPTH  = 16,
    parameter int          DIV_WIDTH   = 16,
    parameter int unsigned DEFAULT_DIV = 2267
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          enable,
    input  logic                          wr_valid,
    input  logic [7:0]                    wr_data,
    output logic                          wr_ready,
    input  logic                          flush,
    input  logic                          div_we,
    input  logic [DIV_WIDTH-1:0]          div_i,
    input  logic                          underrun_clr,
    output logic                          pwm_we,
    output logic [7:0]                    pwm_pcm,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          irq_half,
    output logic                          underrun
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [1:0] {IDLE, PLAY, STARVED} state_t;

    state_t               state_q;
    logic [DIV_WIDTH-1:0] div_q, cnt_q;
    logic [AW-1:0]        wptr_q, rptr_q;
    logic [AW:0]          level_q;
    logic [7:0]           mem_q [FIFO_DEPTH];
    logic [7:0]           pcm_q;
    logic                 pwm_we_q, underrun_q;
    logic                 running, empty, full, tick, push, pop, starve;

    assign running  = state_q != IDLE;
    assign empty    = level_q == '0;
    assign full     = level_q == LW'(FIFO_DEPTH);
    assign wr_ready = !full && !flush;
    assign push     = wr_valid && wr_ready;
    // enable low wins over a coinciding tick; flush makes the tick see an empty FIFO
    assign tick     = running && enable && cnt_q == '0;
    assign pop      = tick && !empty && !flush;
    assign starve   = tick && !pop;

    assign pwm_we     = pwm_we_q;
    assign pwm_pcm    = pcm_q;
    assign fifo_level = level_q;
    assign irq_half   = running && level_q <= LW'(FIFO_DEPTH / 2);
    assign underrun   = underrun_q;

    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= IDLE;
            div_q      <= DIV_WIDTH'(DEFAULT_DIV);
            cnt_q      <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            level_q    <= '0;
            pcm_q      <= 8'h80;
            pwm_we_q   <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            pwm_we_q   <= 1'b0;
            underrun_q <= starve || (underrun_q && !underrun_clr);
            if (div_we) div_q <= div_i;
            if (flush) begin
                wptr_q  <= '0;
                rptr_q  <= '0;
                level_q <= '0;
            end else begin
                if (push) wptr_q <= wptr_q + AW'(1);
                if (pop) rptr_q <= rptr_q + AW'(1);
                level_q <= level_q + LW'(push) - LW'(pop);
            end
            if (!running) begin
                cnt_q <= enable ? div_q : '0;
                if (enable) state_q <= PLAY;
            end else if (!enable) begin
                state_q  <= IDLE;
                cnt_q    <= '0;
                pwm_we_q <= 1'b1;
                pcm_q    <= 8'h80;
            end else begin
                cnt_q <= tick ? div_q : cnt_q - DIV_WIDTH'(1);
                if (pop) begin
                    state_q  <= PLAY;
                    pwm_we_q <= 1'b1;
                    pcm_q    <= mem_q[rptr_q];
                end else if (starve && state_q == PLAY) begin
                    state_q  <= STARVED;
                    pwm_we_q <= 1'b1;
                    pcm_q    <= 8'h80;
                end
            end
        end
    end
endmodule

// File: tb/tb_pcm_stream_ctrl.sv
// tb_pcm_stream_ctrl: directed stimulus with a strobe scoreboard keyed on cycle number.
module tb_pcm_stream_ctrl;
    logic        clk, resetn, enable, wr_valid, flush, div_we, underrun_clr;
    logic [7:0]  wr_data;
    logic [15:0] div_i;
    logic        wr_ready, pwm_we, irq_half, underrun;
    logic [7:0]  pwm_pcm;
    logic [4:0]  fifo_level;

    pcm_stream_ctrl dut (
        .clk(clk), .resetn(resetn), .enable(enable), .wr_valid(wr_valid),
        .wr_data(wr_data), .wr_ready(wr_ready), .flush(flush), .div_we(div_we),
        .div_i(div_i), .underrun_clr(underrun_clr), .pwm_we(pwm_we),
        .pwm_pcm(pwm_pcm), .fifo_level(fifo_level), .irq_half(irq_half),
        .underrun(underrun)
    );

    typedef struct {int c; int v;} exp_t;
    exp_t q[$];
    int   cyc = 0, checks = 0, passes = 0;
    int   c0, d;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string n, input int a, input int e);
        checks++;
        if (a == e) passes++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", n, a, e, cyc);
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic goto(input int t);
        while (cyc < t) step();
    endtask

    task automatic expect_strobe(input int c, input int v);
        exp_t e;
        e.c = c;
        e.v = v;
        q.push_back(e);
    endtask

    task automatic push_byte(input int v);
        wr_valid = 1'b1;
        wr_data  = 8'(v);
        step();
        wr_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (resetn) begin
            if (pwm_we) begin
                if (q.size() == 0) begin
                    checks++;
                    $display("FAIL spurious_strobe: got pcm %0d at cycle %0d expected none", pwm_pcm, cyc);
                end else begin
                    e = q.pop_front();
                    chk("strobe_data", pwm_pcm, e.v);
                    chk("strobe_cycle", cyc, e.c);
                end
            end else if (q.size() != 0 && q[0].c <= cyc) begin
                e = q.pop_front();
                checks++;
                $display("FAIL missed_strobe: none at cycle %0d expected pcm %0d", cyc, e.v);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 0; enable = 0; wr_valid = 0; wr_data = 0; flush = 0;
        div_we = 0; div_i = 0; underrun_clr = 0;
        step(2);
        chk("rst_level", fifo_level, 0);
        chk("rst_wr_ready", wr_ready, 1);
        chk("rst_pwm_we", pwm_we, 0);
        chk("rst_pcm", pwm_pcm, 8'h80);
        chk("rst_underrun", underrun, 0);
        chk("rst_irq", irq_half, 0);
        resetn = 1;
        div_we = 1; div_i = 3;
        step();
        div_we = 0;
        push_byte(8'h10); push_byte(8'h20); push_byte(8'h30);
        chk("level3", fifo_level, 3);

        c0 = cyc;
        enable = 1;
        expect_strobe(c0 + 5, 8'h10);
        expect_strobe(c0 + 9, 8'h20);
        expect_strobe(c0 + 13, 8'h30);
        expect_strobe(c0 + 17, 8'h80);
        step();
        chk("irq_play_low", irq_half, 1);
        goto(c0 + 21);
        chk("underrun_set", underrun, 1);
        chk("level_drained", fifo_level, 0);

        expect_strobe(c0 + 25, 8'h55);
        push_byte(8'h55);
        goto(c0 + 26);
        chk("underrun_sticky", underrun, 1);
        underrun_clr = 1; step(); underrun_clr = 0;
        chk("underrun_cleared", underrun, 0);
        expect_strobe(c0 + 29, 8'h80);
        goto(c0 + 30);
        chk("underrun_reset", underrun, 1);
        goto(c0 + 32);
        underrun_clr = 1; step(); underrun_clr = 0;
        chk("underrun_set_wins", underrun, 1);
        underrun_clr = 1; step(); underrun_clr = 0;
        chk("underrun_cleared2", underrun, 0);

        goto(c0 + 41);
        expect_strobe(c0 + 45, 8'hA1);
        expect_strobe(c0 + 49, 8'hA2);
        expect_strobe(c0 + 50, 8'hA3);
        expect_strobe(c0 + 51, 8'hA4);
        expect_strobe(c0 + 52, 8'h80);
        push_byte(8'hA1); push_byte(8'hA2); push_byte(8'hA3); push_byte(8'hA4);
        div_we = 1; div_i = 0; step(); div_we = 0;
        goto(c0 + 48); chk("div0_level3", fifo_level, 3);
        goto(c0 + 49); chk("div0_level2", fifo_level, 2);
        goto(c0 + 50); chk("div0_level1", fifo_level, 1);
        goto(c0 + 51); chk("div0_level0", fifo_level, 0);

        goto(c0 + 55);
        enable = 0;
        expect_strobe(c0 + 56, 8'h80);
        step();
        underrun_clr = 1;
        for (int k = 0; k < 5; k++) begin
            wr_valid = 1; wr_data = 8'(8'hC0 + k);
            step();
            underrun_clr = 0;
        end
        wr_valid = 0;
        chk("idle_level5", fifo_level, 5);
        chk("irq_idle", irq_half, 0);
        chk("underrun_idle_clr", underrun, 0);
        flush = 1; wr_valid = 1; wr_data = 8'h77;
        #1;
        chk("wr_ready_flush", wr_ready, 0);
        step();
        flush = 0; wr_valid = 0;
        chk("flush_level", fifo_level, 0);
        enable = 1;
        expect_strobe(c0 + 64, 8'h80);
        goto(c0 + 66);
        chk("flush_underrun", underrun, 1);

        enable = 0; div_we = 1; div_i = 3;
        expect_strobe(c0 + 67, 8'h80);
        step();
        div_we = 0;
        for (int k = 0; k < 5; k++) push_byte(8'hD0 + k);
        enable = 1;
        expect_strobe(c0 + 77, 8'hD0);
        goto(c0 + 78);
        chk("stop_level4", fifo_level, 4);
        enable = 0;
        expect_strobe(c0 + 79, 8'h80);
        goto(c0 + 80);
        chk("stopped_level4", fifo_level, 4);
        enable = 1;
        expect_strobe(c0 + 85, 8'hD1);
        expect_strobe(c0 + 89, 8'hD2);
        expect_strobe(c0 + 93, 8'hD3);
        expect_strobe(c0 + 97, 8'hD4);
        expect_strobe(c0 + 101, 8'h80);
        goto(c0 + 103);
        enable = 0;
        expect_strobe(c0 + 104, 8'h80);
        goto(c0 + 106);

        resetn = 0; step(2); resetn = 1;
        chk("rst2_level", fifo_level, 0);
        chk("rst2_state_irq", irq_half, 0);
        for (int i = 0; i < 17; i++) begin
            wr_valid = 1; wr_data = 8'(i);
            if (i == 16) chk("wr_ready_full", wr_ready, 0);
            step();
        end
        wr_valid = 0;
        chk("full_level16", fifo_level, 16);
        chk("full_irq_idle", irq_half, 0);
        d = cyc;
        div_we = 1; div_i = 0; step(); div_we = 0;
        enable = 1;
        for (int k = 0; k < 16; k++) expect_strobe(d + 3 + k, k);
        expect_strobe(d + 19, 8'h80);
        step();
        chk("irq_play_full", irq_half, 0);
        wr_valid = 1; wr_data = 8'hEE;
        chk("wr_ready_full_pop", wr_ready, 0);
        step();
        wr_valid = 0;
        chk("full_pop_level", fifo_level, 15);
        goto(d + 9);
        chk("level9", fifo_level, 9);
        chk("irq_level9", irq_half, 0);
        goto(d + 10);
        chk("level8", fifo_level, 8);
        chk("irq_level8", irq_half, 1);
        goto(d + 25);
        chk("final_underrun", underrun, 1);
        chk("queue_empty", q.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
